// File: rtl/enum_type.sv
// Shared game-core state/command encoding used by the core and its input front end.
package enum_type;

    typedef enum logic [3:0] {
        NONE, INIT, WAIT, MCHECK, END,
        DOWN, LEFT, RIGHT, ROTATE, ROTATE_REV, DROP, HOLD, BAR
    } state_type;

endpackage

// File: rtl/tetris_repeat.sv
// Auto-repeat for one held button: pulse on press, again DAS cycles later,
// then every ARR cycles until release.
module tetris_repeat #(
    parameter int DAS = 20_000_000,
    parameter int ARR = 5_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic btn,
    output logic evt
);

    localparam logic [31:0] DAS_C = 32'(DAS);
    localparam logic [31:0] ARR_C = 32'(ARR);

    logic        lvl_q, lvl_d;
    logic        rep_q, rep_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        lvl_d = btn;
        cnt_d = cnt_q;
        rep_d = rep_q;
        evt   = 1'b0;
        if (btn && !lvl_q) begin
            evt   = 1'b1;
            cnt_d = 32'd1;
            rep_d = 1'b0;
        end else if (btn && cnt_q != 32'd0) begin
            // A zero timer while held means repeat was cancelled; stay idle until next press.
            if (cnt_q == (rep_q ? ARR_C : DAS_C)) begin
                evt   = 1'b1;
                cnt_d = 32'd1;
                rep_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            cnt_d = 32'd0;
            rep_d = 1'b0;
        end
        if (clr) begin
            cnt_d = 32'd0;
            rep_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q <= 1'b0;
            rep_q <= 1'b0;
            cnt_q <= 32'd0;
        end else begin
            lvl_q <= lvl_d;
            rep_q <= rep_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tetris_input.sv
// Input front end: turns buttons, gravity and garbage requests into one
// registered command at a time for the game core, with fixed priority.
module tetris_input
    import enum_type::*;
#(
    parameter int GRAV_BASE = 50_000_000,
    parameter int GRAV_STEP = 4_500_000,
    parameter int DAS       = 20_000_000,
    parameter int ARR       = 5_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_rotate,
    input  logic        btn_rotate_rev,
    input  logic        btn_down,
    input  logic        btn_drop,
    input  logic        btn_hold,
    input  logic        bar_req,
    input  logic [31:0] rng,
    input  state_type   state,
    input  logic [15:0] score,
    output state_type   ctrl,
    output logic [9:0]  bar_mask,
    output logic [3:0]  level
);

    localparam int P_DROP = 0, P_HOLD = 1, P_ROT = 2, P_ROTR = 3, P_LEFT = 4;
    localparam int P_RIGHT = 5, P_SDOWN = 6, P_GDOWN = 7, P_BAR = 8;

    logic [6:0]  btn_q, btn_d, btn_vec, press;
    logic [2:0]  rep_btn, rep_evt;
    logic [8:0]  pend_q, pend_d, issue_src;
    logic [9:0]  mask_q, mask_d;
    logic [3:0]  level_q, level_d, bar_idx;
    logic [31:0] grav_q, grav_d, period_m1;
    state_type   ctrl_q, ctrl_d;
    logic        play, accept, grav_tick;
    logic        unused_ok;

    assign btn_vec   = {btn_hold, btn_drop, btn_down, btn_rotate_rev, btn_rotate, btn_right, btn_left};
    assign rep_btn   = {btn_down, btn_right, btn_left};
    assign unused_ok = ^{rng[31:4], score[3:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rep
            tetris_repeat #(.DAS(DAS), .ARR(ARR)) u_rep (
                .clk     (clk),
                .reset_n (reset_n),
                .clr     (!play),
                .btn     (rep_btn[gi]),
                .evt     (rep_evt[gi])
            );
        end
    endgenerate

    always_comb begin
        play      = (state != INIT) && (state != END);
        accept    = (ctrl_q != NONE) && ((state == WAIT) || !play);
        press     = btn_vec & ~btn_q;
        btn_d     = btn_vec;
        level_d   = (score[15:8] == 8'd0) ? score[7:4] : 4'd9;
        period_m1 = 32'(GRAV_BASE) - 32'(level_q) * 32'(GRAV_STEP) - 32'd1;
        // >= so a level increase mid-count fires immediately instead of wrapping.
        grav_tick = play && (grav_q >= period_m1);
        bar_idx   = rng[3:0] % 4'd10;

        if (!play || grav_tick || (accept && (ctrl_q == DOWN || ctrl_q == DROP)))
            grav_d = 32'd0;
        else
            grav_d = grav_q + 32'd1;

        pend_d = pend_q;
        mask_d = mask_q;
        if (play) begin
            if (press[5])   pend_d[P_DROP]  = 1'b1;
            if (press[6])   pend_d[P_HOLD]  = 1'b1;
            if (press[2])   pend_d[P_ROT]   = 1'b1;
            if (press[3])   pend_d[P_ROTR]  = 1'b1;
            if (rep_evt[0]) pend_d[P_LEFT]  = 1'b1;
            if (rep_evt[1]) pend_d[P_RIGHT] = 1'b1;
            if (rep_evt[2]) pend_d[P_SDOWN] = 1'b1;
            if (grav_tick)  pend_d[P_GDOWN] = 1'b1;
            if (bar_req && !pend_q[P_BAR]) begin
                pend_d[P_BAR] = 1'b1;
                mask_d        = 10'd1 << bar_idx;
            end
        end else begin
            pend_d = '0;
            mask_d = '0;
            if (|press) pend_d[P_SDOWN] = 1'b1;
        end
        if (accept) begin
            case (ctrl_q)
                DROP:       pend_d[P_DROP]  = 1'b0;
                HOLD:       pend_d[P_HOLD]  = 1'b0;
                ROTATE:     pend_d[P_ROT]   = 1'b0;
                ROTATE_REV: pend_d[P_ROTR]  = 1'b0;
                LEFT:       pend_d[P_LEFT]  = 1'b0;
                RIGHT:      pend_d[P_RIGHT] = 1'b0;
                DOWN: begin
                    pend_d[P_SDOWN] = 1'b0;
                    pend_d[P_GDOWN] = 1'b0;
                end
                BAR: begin
                    pend_d[P_BAR] = 1'b0;
                    mask_d        = '0;
                end
                default: ;
            endcase
        end

        // Outside play only the start command may be issued.
        issue_src = play ? pend_q : (pend_q & 9'(1 << P_SDOWN));
        ctrl_d    = ctrl_q;
        if (accept) begin
            ctrl_d = NONE;
        end else if (ctrl_q == NONE) begin
            if      (issue_src[P_DROP])  ctrl_d = DROP;
            else if (issue_src[P_HOLD])  ctrl_d = HOLD;
            else if (issue_src[P_ROT])   ctrl_d = ROTATE;
            else if (issue_src[P_ROTR])  ctrl_d = ROTATE_REV;
            else if (issue_src[P_LEFT])  ctrl_d = LEFT;
            else if (issue_src[P_RIGHT]) ctrl_d = RIGHT;
            else if (issue_src[P_SDOWN] || issue_src[P_GDOWN]) ctrl_d = DOWN;
            else if (issue_src[P_BAR])   ctrl_d = BAR;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            level_q <= '0;
            grav_q  <= '0;
            ctrl_q  <= NONE;
        end else begin
            btn_q   <= btn_d;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            level_q <= level_d;
            grav_q  <= grav_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ctrl     = ctrl_q;
    assign bar_mask = mask_q;
    assign level    = level_q;

endmodule

// File: tb/tb_tetris_input.sv
// Directed bench for tetris_input: table of single-press/garbage vectors plus
// hand-written gravity, auto-repeat, end-state and async-reset sequences.
module tb_tetris_input;
    import enum_type::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_left = 0, btn_right = 0, btn_rotate = 0, btn_rotate_rev = 0;
    logic        btn_down = 0, btn_drop = 0, btn_hold = 0, bar_req = 0;
    logic [31:0] rng = '0;
    state_type   state = WAIT;
    logic [15:0] score = '0;
    state_type   ctrl;
    logic [9:0]  bar_mask;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;

    tetris_input #(.GRAV_BASE(100), .GRAV_STEP(10), .DAS(8), .ARR(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_rotate(btn_rotate),
        .btn_rotate_rev(btn_rotate_rev), .btn_down(btn_down), .btn_drop(btn_drop),
        .btn_hold(btn_hold), .bar_req(bar_req), .rng(rng), .state(state),
        .score(score), .ctrl(ctrl), .bar_mask(bar_mask), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic [15:0] score;
        logic [3:0] rng4;
        state_type  exp_ctrl;
        logic [3:0] exp_level;
        logic [9:0] exp_mask;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_btn(input int sel, input logic v);
        case (sel)
            0: btn_left = v;
            1: btn_right = v;
            2: btn_rotate = v;
            3: btn_rotate_rev = v;
            4: btn_down = v;
            5: btn_drop = v;
            6: btn_hold = v;
            default: bar_req = v;
        endcase
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) set_btn(i, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_ctrl(input state_type target, input int limit, output int n);
        n = 0;
        while (ctrl != target && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int nleft;
        int offs[8];
        int exp_offs[5];
        int busy;
        state_type prev;

        tbl[0]  = '{0, 16'h0000, 4'd0,  LEFT,       4'd0, 10'h000};
        tbl[1]  = '{1, 16'h0020, 4'd0,  RIGHT,      4'd2, 10'h000};
        tbl[2]  = '{2, 16'h0045, 4'd0,  ROTATE,     4'd4, 10'h000};
        tbl[3]  = '{3, 16'h0090, 4'd0,  ROTATE_REV, 4'd9, 10'h000};
        tbl[4]  = '{4, 16'h0100, 4'd0,  DOWN,       4'd9, 10'h000};
        tbl[5]  = '{5, 16'h0010, 4'd0,  DROP,       4'd1, 10'h000};
        tbl[6]  = '{6, 16'h0080, 4'd0,  HOLD,       4'd8, 10'h000};
        tbl[7]  = '{7, 16'h0030, 4'd13, BAR,        4'd3, 10'h008};
        tbl[8]  = '{7, 16'h0000, 4'd9,  BAR,        4'd0, 10'h200};
        tbl[9]  = '{7, 16'h0070, 4'd10, BAR,        4'd7, 10'h001};
        tbl[10] = '{7, 16'h1234, 4'd15, BAR,        4'd9, 10'h020};
        tbl[11] = '{7, 16'h0055, 4'd0,  BAR,        4'd5, 10'h001};
        exp_offs = '{0, 8, 11, 14, 17};

        // Reset state, with a nonzero score applied during reset.
        score = 16'h0090;
        reset_n = 1'b0;
        tick();
        tick();
        check("reset_ctrl", 32'(ctrl), 32'(NONE));
        check("reset_mask", 32'(bar_mask), 32'h0);
        check("reset_level", 32'(level), 32'h0);

        // Table: one press or garbage request under MCHECK, then accept under WAIT.
        for (int r = 0; r < 12; r++) begin
            state = MCHECK;
            score = tbl[r].score;
            rng   = {28'h0, tbl[r].rng4};
            do_reset();
            tick();
            tick();
            set_btn(tbl[r].sel, 1'b1);
            tick();
            set_btn(tbl[r].sel, 1'b0);
            tick();
            tick();
            check($sformatf("row%0d_ctrl", r), 32'(ctrl), 32'(tbl[r].exp_ctrl));
            check($sformatf("row%0d_level", r), 32'(level), 32'(tbl[r].exp_level));
            check($sformatf("row%0d_mask", r), 32'(bar_mask), 32'(tbl[r].exp_mask));
            state = WAIT;
            tick();
            check($sformatf("row%0d_acc_ctrl", r), 32'(ctrl), 32'(NONE));
            check($sformatf("row%0d_acc_mask", r), 32'(bar_mask), 32'h0);
            $display("row %0d sel=%0d score=%h rng=%0d done", r, tbl[r].sel, tbl[r].score, tbl[r].rng4);
        end

        // Gravity at level 0, then at level 3.
        state = WAIT;
        score = 16'h0000;
        do_reset();
        wait_ctrl(DOWN, 200, n);
        check_rng("grav_first", n, 100, 102);
        tick();
        check("grav_acc", 32'(ctrl), 32'(NONE));
        wait_ctrl(DOWN, 200, n);
        check_rng("grav_period0", n, 100, 102);
        score = 16'h0030;
        tick();
        wait_ctrl(DOWN, 200, n);
        tick();
        check("grav_acc3", 32'(ctrl), 32'(NONE));
        wait_ctrl(DOWN, 200, n);
        check_rng("grav_period3", n, 70, 72);
        check("grav_level3", 32'(level), 32'h3);
        $display("gravity sequence done");

        // Rotate beats left when pressed together; left follows after acceptance.
        state = MCHECK;
        score = 16'h0000;
        do_reset();
        tick();
        btn_left = 1'b1;
        btn_rotate = 1'b1;
        tick();
        btn_left = 1'b0;
        btn_rotate = 1'b0;
        tick();
        tick();
        check("prio_rot", 32'(ctrl), 32'(ROTATE));
        tick();
        tick();
        tick();
        check("prio_rot_hold", 32'(ctrl), 32'(ROTATE));
        state = WAIT;
        tick();
        check("prio_acc", 32'(ctrl), 32'(NONE));
        tick();
        check("prio_left", 32'(ctrl), 32'(LEFT));
        $display("priority sequence done");

        // Auto-repeat of a held left button.
        state = WAIT;
        do_reset();
        tick();
        btn_left = 1'b1;
        nleft = 0;
        prev = NONE;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 19) btn_left = 1'b0;
            if (ctrl == LEFT && prev != LEFT) begin
                if (nleft < 8) offs[nleft] = i;
                nleft++;
            end
            prev = ctrl;
        end
        check("rep_count", 32'(nleft), 32'd5);
        for (int k = 1; k < 5; k++)
            if (k < nleft)
                check($sformatf("rep_off%0d", k), 32'(offs[k] - offs[0]), 32'(exp_offs[k]));
        $display("repeat sequence done");

        // Leaving play drops pending work.
        state = MCHECK;
        do_reset();
        tick();
        btn_rotate = 1'b1;
        btn_hold = 1'b1;
        tick();
        btn_rotate = 1'b0;
        btn_hold = 1'b0;
        tick();
        tick();
        check("leave_hold", 32'(ctrl), 32'(HOLD));
        state = END;
        tick();
        state = WAIT;
        tick();
        tick();
        tick();
        check("leave_clear", 32'(ctrl), 32'(NONE));
        $display("leave-play sequence done");

        // END state: idle, then a press issues the start command.
        state = END;
        do_reset();
        busy = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ctrl != NONE) busy++;
        end
        check("end_idle", 32'(busy), 32'd0);
        btn_drop = 1'b1;
        tick();
        btn_drop = 1'b0;
        wait_ctrl(DOWN, 5, n);
        check("end_start", 32'(ctrl), 32'(DOWN));
        tick();
        check("end_start_acc", 32'(ctrl), 32'(NONE));
        $display("end-state sequence done");

        // Asynchronous reset while BAR is outstanding.
        state = MCHECK;
        score = 16'h0030;
        do_reset();
        rng = 32'h0000_000D;
        bar_req = 1'b1;
        tick();
        bar_req = 1'b0;
        tick();
        tick();
        check("areset_pre_ctrl", 32'(ctrl), 32'(BAR));
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_ctrl", 32'(ctrl), 32'(NONE));
        check("areset_mask", 32'(bar_mask), 32'h0);
        check("areset_level", 32'(level), 32'h0);
        $display("async reset sequence done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
